pio_arb: RTL and testbench
==========================

# pio_arb

Arbiter and strobe sequencer for the shared ISP1362 16-bit PIO bus. Two requesters, the host-controller interface (HC) and the device-controller interface (DC), issue single-word command or data accesses. The block grants the bus round-robin and drives chip-select, address and read/write strobes with parameterised setup, strobe-width and recovery timing. It returns read data and a one-cycle acknowledge. It sits between the HC/DC interface logic and the board-level tristate on the data bus.

## Interface
- SETUP_CYC, 1: cycles of CSF/ADDR (and write data) valid before strobe falls; range 1..255
- STRB_CYC, 4: RDF/WRF low width in cycles (80 ns at 50 MHz); range 1..255
- RECOV_CYC, 8: cycles with CSF high between accesses (160 ns); range 0..255

Ports (one clock; reset is asynchronous and active-low):
- I_CLK  in  1  clock, 50 MHz
- I_RSTF  in  1  reset, asynchronous, active low
- I_HC_REQ / I_DC_REQ  in  1  access request; held high until ACK
- I_HC_WR / I_DC_WR  in  1  1 = write, 0 = read
- I_HC_CMD / I_DC_CMD  in  1  1 = command port, 0 = data port
- I_HC_WDATA / I_DC_WDATA  in  16  write data
- O_HC_ACK / O_DC_ACK  out  1  one-cycle completion pulse
- O_HC_RDATA / O_DC_RDATA  out  16  read data; valid from ACK until that requester's next ACK
- O_ADDR  out  2  [1] = granted requester (HC = 0, DC = 1); [0] = CMD bit
- O_CSF, O_RDF, O_WRF  out  1  active-low chip select and strobes
- O_DOUT  out  16  write data to pad
- O_DOE  out  1  pad output enable
- I_DIN  in  16  read data from pad
- O_BUSY  out  1  high in every state except IDLE
- O_GRANT  out  1  current or last owner (0 = HC, 1 = DC)

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. An 8-bit down-counter times SETUP, STROBE and RECOVER.
- IDLE: if any request is high, select an owner. Latch its WR, CMD and WDATA, then go to SETUP.
- Arbitration is round-robin on a last-owner pointer:
  - Sole requester wins.
  - If both request, the one that is not the last owner wins.
  - Pointer reset value = HC, so DC wins the first tie.
- SETUP, SETUP_CYC cycles:
  - CSF = 0, ADDR valid.
  - Writes only: DOE = 1, DOUT = latched data.
- STROBE, STRB_CYC cycles: RDF = 0 (read) or WRF = 0 (write). CSF, ADDR, DOE and DOUT are unchanged.
- Read data: I_DIN is sampled into the owner's RDATA register at the clock edge that ends the last STROBE cycle.
- HOLD, 1 cycle:
  - Strobes high; CSF = 0, ADDR and DOE held.
  - Owner's ACK = 1.
  - Last-owner pointer updates to the owner.
- RECOVER, RECOV_CYC cycles: CSF = 1, DOE = 0, ADDR holds its value. If RECOV_CYC = 0, HOLD goes directly to IDLE.
- Requester and request rules:
  - A requester must deassert REQ in the cycle after its ACK.
  - REQ still high at the return to IDLE is a new request.
  - WR, CMD and WDATA must be stable while REQ is high; they are only sampled at grant.
  - A REQ that drops before grant is a cancelled request; no ACK is issued.
- The non-owner's request waits without loss. It is served next if it is still high at IDLE.
- Reset values, asynchronous, at any state including mid-strobe:
  - CSF = RDF = WRF = 1, DOE = 0, ADDR = 0, DOUT = 0.
  - ACKs = 0, RDATAs = 0, BUSY = 0, GRANT = 0.
  - Pointer = HC, state = IDLE.
  - An access aborted by reset never ACKs.
- All outputs are registered.

## Timing
- REQ first sampled high at edge 0 gives: SETUP in cycles 1..SETUP_CYC, then STROBE, then HOLD.
- ACK cycle = 1 + SETUP_CYC + STRB_CYC after edge 0. Defaults: strobe low in cycles 2–5, ACK in cycle 6.
- Back-to-back access period (SETUP to SETUP) = SETUP_CYC + STRB_CYC + 1 + RECOV_CYC + 1. Defaults: 15 cycles; the second SETUP is at cycle 16.
- RDF and WRF are never low together. Strobes are never low while CSF = 1.
- CSF high time between accesses ≥ RECOV_CYC + 1 cycles (RECOVER plus IDLE).

## Test plan
- Single HC write, CMD = 1, WDATA = 0x00AA, defaults:
  - ADDR = 01, CSF low cycles 1–6, WRF low cycles 2–5, DOE high cycles 1–6.
  - O_HC_ACK in cycle 6 only.
- Single DC read, I_DIN = 0x3630 during strobe:
  - ADDR = 10, RDF low 4 cycles, O_DC_RDATA = 0x3630 at ACK, DOE stays 0.
- HC and DC request simultaneously from reset:
  - DC served first (ACK cycle 6), HC second (ACK cycle 21).
  - Repeat the simultaneous request: HC is not served twice in a row.
- Timing parameters SETUP_CYC = 2, STRB_CYC = 1, RECOV_CYC = 0:
  - Strobe low 1 cycle, ACK at cycle 4, next SETUP at cycle 6.
- Assert I_RSTF = 0 in the second strobe cycle of a write:
  - Same cycle, asynchronously: WRF = CSF = 1, DOE = 0.
  - No ACK; after release, a new request completes normally.
- Random REQ traffic for 10k cycles: check with assertions.
  - No RDF/WRF overlap.
  - Exactly one ACK per granted request.
  - CSF high gap ≥ RECOV_CYC + 1.

Source files
------------

// File: rtl/pio_arb.sv
// pio_arb: arbiter and strobe sequencer for the shared ISP1362 16-bit PIO bus.
//
// Two requesters (HC = host-controller side, DC = device-controller side)
// issue single-word command/data accesses. Ties are broken round-robin on
// the last owner. Each access runs SETUP -> STROBE -> HOLD -> RECOVER with
// parameterised cycle counts. All outputs are registered.
//
// Parameters:
//   SETUP_CYC  CSF/ADDR (and write data) valid before the strobe falls, 1..255
//   STRB_CYC   RDF/WRF low width in cycles, 1..255
//   RECOV_CYC  CSF-high cycles between accesses, 0..255
//
// Ports:
//   I_CLK, I_RSTF                    clock, asynchronous active-low reset
//   I_HC_REQ/WR/CMD/WDATA            HC access request, direction, port, data
//   I_DC_REQ/WR/CMD/WDATA            DC access request, direction, port, data
//   O_HC_ACK, O_DC_ACK               one-cycle completion pulses
//   O_HC_RDATA, O_DC_RDATA           read data held until that side's next ACK
//   O_ADDR                           {granted requester, CMD bit}
//   O_CSF, O_RDF, O_WRF              active-low chip select and strobes
//   O_DOUT, O_DOE, I_DIN             pad write data, output enable, read data
//   O_BUSY                           high in every state except IDLE
//   O_GRANT                          current or last owner (0 = HC, 1 = DC)
module pio_arb #(
    parameter int SETUP_CYC = 1,
    parameter int STRB_CYC  = 4,
    parameter int RECOV_CYC = 8
) (
    input  logic        I_CLK,
    input  logic        I_RSTF,
    input  logic        I_HC_REQ,
    input  logic        I_HC_WR,
    input  logic        I_HC_CMD,
    input  logic [15:0] I_HC_WDATA,
    input  logic        I_DC_REQ,
    input  logic        I_DC_WR,
    input  logic        I_DC_CMD,
    input  logic [15:0] I_DC_WDATA,
    output logic        O_HC_ACK,
    output logic        O_DC_ACK,
    output logic [15:0] O_HC_RDATA,
    output logic [15:0] O_DC_RDATA,
    output logic [1:0]  O_ADDR,
    output logic        O_CSF,
    output logic        O_RDF,
    output logic        O_WRF,
    output logic [15:0] O_DOUT,
    output logic        O_DOE,
    input  logic [15:0] I_DIN,
    output logic        O_BUSY,
    output logic        O_GRANT
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

    // Counter load values: each timed phase counts down to zero inclusive.
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STRB_LD  = 8'(STRB_CYC - 1);
    localparam logic [7:0] RECOV_LD = 8'((RECOV_CYC > 0) ? (RECOV_CYC - 1) : 0);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        last_owner, last_owner_nx;
    logic        owner, owner_nx;
    logic        wr, wr_nx;
    logic [1:0]  addr, addr_nx;
    logic [15:0] dout, dout_nx;
    logic [15:0] hc_rdata, hc_rdata_nx;
    logic [15:0] dc_rdata, dc_rdata_nx;
    logic        csf, csf_nx;
    logic        rdf, rdf_nx;
    logic        wrf, wrf_nx;
    logic        doe, doe_nx;
    logic        busy, busy_nx;
    logic        hc_ack, hc_ack_nx;
    logic        dc_ack, dc_ack_nx;
    logic        pick_dc;
    logic        on_bus;

    // DC wins when it is alone, or on a tie when HC owned the bus last.
    assign pick_dc = I_DC_REQ && (!I_HC_REQ || !last_owner);

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        last_owner_nx = last_owner;
        owner_nx      = owner;
        wr_nx         = wr;
        addr_nx       = addr;
        dout_nx       = dout;
        hc_rdata_nx   = hc_rdata;
        dc_rdata_nx   = dc_rdata;

        case (state)
            IDLE: begin
                if (I_HC_REQ || I_DC_REQ) begin
                    owner_nx = pick_dc;
                    wr_nx    = pick_dc ? I_DC_WR : I_HC_WR;
                    addr_nx  = {pick_dc, pick_dc ? I_DC_CMD : I_HC_CMD};
                    // The pad register only changes for writes so reads
                    // never toggle the data lines.
                    if (wr_nx) begin
                        dout_nx = pick_dc ? I_DC_WDATA : I_HC_WDATA;
                    end
                    cnt_nx   = SETUP_LD;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    cnt_nx   = STRB_LD;
                    state_nx = STROBE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            STROBE: begin
                if (cnt == 8'd0) begin
                    // Read data is captured on the edge that ends the strobe.
                    if (!wr) begin
                        if (owner) begin
                            dc_rdata_nx = I_DIN;
                        end else begin
                            hc_rdata_nx = I_DIN;
                        end
                    end
                    state_nx = HOLD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            HOLD: begin
                last_owner_nx = owner;
                if (RECOV_CYC == 0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx   = RECOV_LD;
                    state_nx = RECOVER;
                end
            end
            RECOVER: begin
                if (cnt == 8'd0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with
        // the state they describe.
        on_bus    = (state_nx == SETUP) || (state_nx == STROBE) || (state_nx == HOLD);
        csf_nx    = !on_bus;
        rdf_nx    = !((state_nx == STROBE) && !wr_nx);
        wrf_nx    = !((state_nx == STROBE) && wr_nx);
        doe_nx    = on_bus && wr_nx;
        busy_nx   = (state_nx != IDLE);
        hc_ack_nx = (state_nx == HOLD) && !owner_nx;
        dc_ack_nx = (state_nx == HOLD) && owner_nx;
    end

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            last_owner <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            last_owner <= last_owner_nx;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            owner    <= 1'b0;
            wr       <= 1'b0;
            addr     <= 2'b00;
            dout     <= 16'h0000;
            hc_rdata <= 16'h0000;
            dc_rdata <= 16'h0000;
            csf      <= 1'b1;
            rdf      <= 1'b1;
            wrf      <= 1'b1;
            doe      <= 1'b0;
            busy     <= 1'b0;
            hc_ack   <= 1'b0;
            dc_ack   <= 1'b0;
        end else begin
            owner    <= owner_nx;
            wr       <= wr_nx;
            addr     <= addr_nx;
            dout     <= dout_nx;
            hc_rdata <= hc_rdata_nx;
            dc_rdata <= dc_rdata_nx;
            csf      <= csf_nx;
            rdf      <= rdf_nx;
            wrf      <= wrf_nx;
            doe      <= doe_nx;
            busy     <= busy_nx;
            hc_ack   <= hc_ack_nx;
            dc_ack   <= dc_ack_nx;
        end
    end

    assign O_HC_ACK   = hc_ack;
    assign O_DC_ACK   = dc_ack;
    assign O_HC_RDATA = hc_rdata;
    assign O_DC_RDATA = dc_rdata;
    assign O_ADDR     = addr;
    assign O_CSF      = csf;
    assign O_RDF      = rdf;
    assign O_WRF      = wrf;
    assign O_DOUT     = dout;
    assign O_DOE      = doe;
    assign O_BUSY     = busy;
    assign O_GRANT    = owner;

endmodule

// File: tb/tb_pio_arb.sv
// tb_pio_arb: directed and randomized bench for pio_arb.
// Instance u_dut uses default timing, u_dut2 uses SETUP=2, STRB=1, RECOV=0.
module tb_pio_arb;

    localparam int S  = 1, B  = 4, R  = 8;
    localparam int S2 = 2, B2 = 1, R2 = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        hc_req = 0, dc_req = 0, hc_wr = 0, dc_wr = 0, hc_cmd = 0, dc_cmd = 0;
    logic [15:0] hc_wdata = 0, dc_wdata = 0, din = 0;
    logic        b_hc_req = 0, b_dc_req = 0;

    logic        hc_ack, dc_ack, csf, rdf, wrf, doe, busy, grant;
    logic [15:0] hc_rdata, dc_rdata, dout;
    logic [1:0]  addr;
    logic        b_hc_ack, b_dc_ack, b_csf, b_rdf, b_wrf, b_doe, b_busy, b_grant;
    logic [15:0] b_hc_rdata, b_dc_rdata, b_dout;
    logic [1:0]  b_addr;

    pio_arb #(.SETUP_CYC(S), .STRB_CYC(B), .RECOV_CYC(R)) u_dut (
        .I_CLK(clk), .I_RSTF(rst_n),
        .I_HC_REQ(hc_req), .I_HC_WR(hc_wr), .I_HC_CMD(hc_cmd), .I_HC_WDATA(hc_wdata),
        .I_DC_REQ(dc_req), .I_DC_WR(dc_wr), .I_DC_CMD(dc_cmd), .I_DC_WDATA(dc_wdata),
        .O_HC_ACK(hc_ack), .O_DC_ACK(dc_ack), .O_HC_RDATA(hc_rdata), .O_DC_RDATA(dc_rdata),
        .O_ADDR(addr), .O_CSF(csf), .O_RDF(rdf), .O_WRF(wrf), .O_DOUT(dout), .O_DOE(doe),
        .I_DIN(din), .O_BUSY(busy), .O_GRANT(grant)
    );

    pio_arb #(.SETUP_CYC(S2), .STRB_CYC(B2), .RECOV_CYC(R2)) u_dut2 (
        .I_CLK(clk), .I_RSTF(rst_n),
        .I_HC_REQ(b_hc_req), .I_HC_WR(hc_wr), .I_HC_CMD(hc_cmd), .I_HC_WDATA(hc_wdata),
        .I_DC_REQ(b_dc_req), .I_DC_WR(dc_wr), .I_DC_CMD(dc_cmd), .I_DC_WDATA(dc_wdata),
        .O_HC_ACK(b_hc_ack), .O_DC_ACK(b_dc_ack), .O_HC_RDATA(b_hc_rdata), .O_DC_RDATA(b_dc_rdata),
        .O_ADDR(b_addr), .O_CSF(b_csf), .O_RDF(b_rdf), .O_WRF(b_wrf), .O_DOUT(b_dout), .O_DOE(b_doe),
        .I_DIN(din), .O_BUSY(b_busy), .O_GRANT(b_grant)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Per-cycle traces, bit k = cycle k after the request edge; 1 = asserted.
    logic [63:0] v_csf, v_rdf, v_wrf, v_doe, v_hack, v_dack, v_busy;
    logic [63:0] w_csf, w_rdf, w_wrf, w_hack, w_dack;
    logic [1:0]  r_addr  [0:63];
    logic [15:0] r_dout  [0:63];
    logic [15:0] r_hcr   [0:63];
    logic [15:0] r_dcr   [0:63];
    logic        r_grant [0:63];

    // Reference-model state for the random phase.
    int          next_idle, a_ack, a_smp, csf_run, n_exp_ack, n_seen_ack;
    bit          last, a_own, a_wr, a_cmd, seen_low, exp_h, exp_d;
    logic [15:0] a_wd;
    logic [15:0] exp_rd [0:1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] v;
        v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Call at a negedge with requests already set; requesters drop REQ on ACK.
    task automatic run_trace(input int n);
        v_csf = '0; v_rdf = '0; v_wrf = '0; v_doe = '0; v_hack = '0; v_dack = '0; v_busy = '0;
        w_csf = '0; w_rdf = '0; w_wrf = '0; w_hack = '0; w_dack = '0;
        @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            v_csf[k] = ~csf;  v_rdf[k] = ~rdf;  v_wrf[k] = ~wrf;  v_doe[k] = doe;
            v_hack[k] = hc_ack; v_dack[k] = dc_ack; v_busy[k] = busy;
            r_addr[k] = addr; r_dout[k] = dout; r_hcr[k] = hc_rdata; r_dcr[k] = dc_rdata;
            r_grant[k] = grant;
            w_csf[k] = ~b_csf; w_rdf[k] = ~b_rdf; w_wrf[k] = ~b_wrf;
            w_hack[k] = b_hc_ack; w_dack[k] = b_dc_ack;
            if (hc_ack)   hc_req   = 1'b0;
            if (dc_ack)   dc_req   = 1'b0;
            if (b_hc_ack) b_hc_req = 1'b0;
            if (b_dc_ack) b_dc_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hc_req = 0; dc_req = 0; b_hc_req = 0; b_dc_req = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {csf, rdf, wrf, doe, addr, busy, grant, hc_ack, dc_ack}, 10'b1110000000);
        chk("reset_data", {dout, hc_rdata, dc_rdata}, 48'h0);
        rst_n = 1'b1;

        // Single HC write, command port
        hc_req = 1; hc_wr = 1; hc_cmd = 1; hc_wdata = 16'h00AA;
        run_trace(16);
        chk("t1_csf",  v_csf,  span(1, S + B + 1));
        chk("t1_wrf",  v_wrf,  span(S + 1, S + B));
        chk("t1_rdf",  v_rdf,  64'h0);
        chk("t1_doe",  v_doe,  span(1, S + B + 1));
        chk("t1_hack", v_hack, span(S + B + 1, S + B + 1));
        chk("t1_dack", v_dack, 64'h0);
        chk("t1_busy", v_busy, span(1, S + B + 1 + R));
        chk("t1_addr", r_addr[3], 2'b01);
        chk("t1_dout", r_dout[3], 16'h00AA);

        // Single DC read, data port
        dc_req = 1; dc_wr = 0; dc_cmd = 0; din = 16'h3630;
        run_trace(16);
        chk("t2_csf",  v_csf,  span(1, S + B + 1));
        chk("t2_rdf",  v_rdf,  span(S + 1, S + B));
        chk("t2_wrf",  v_wrf,  64'h0);
        chk("t2_doe",  v_doe,  64'h0);
        chk("t2_dack", v_dack, span(S + B + 1, S + B + 1));
        chk("t2_addr", r_addr[3], 2'b10);
        chk("t2_grant", r_grant[3], 1'b1);
        chk("t2_rdata_pre", r_dcr[S + B], 16'h0000);
        chk("t2_rdata_ack", r_dcr[S + B + 1], 16'h3630);
        chk("t2_rdata_hold", r_dcr[16], 16'h3630);
        chk("t2_hc_rdata", r_hcr[16], 16'h0000);

        // Simultaneous requests from reset: DC first, then HC
        do_reset();
        hc_req = 1; hc_wr = 1; hc_cmd = 0; hc_wdata = 16'h1234;
        dc_req = 1; dc_wr = 0; dc_cmd = 1; din = 16'h5A5A;
        run_trace(36);
        chk("t3_dack", v_dack, span(6, 6));
        chk("t3_hack", v_hack, span(21, 21));
        chk("t3_csf",  v_csf,  span(1, 6) | span(16, 21));
        chk("t3_grant_dc", r_grant[3], 1'b1);
        chk("t3_grant_hc", r_grant[18], 1'b0);
        chk("t3_addr_dc", r_addr[3], 2'b11);
        chk("t3_dout_hc", r_dout[18], 16'h1234);
        chk("t3_rdata_dc", r_dcr[6], 16'h5A5A);
        // Repeat: HC was last owner, so DC wins the tie again
        hc_req = 1; hc_wdata = 16'h4321; dc_req = 1;
        run_trace(36);
        chk("t3b_dack", v_dack, span(6, 6));
        chk("t3b_hack", v_hack, span(21, 21));

        // Fast timing instance: DC read then HC write back to back
        b_dc_req = 1; b_hc_req = 1; dc_wr = 0; hc_wr = 1;
        run_trace(12);
        chk("t4_csf",  w_csf,  span(1, 4) | span(6, 9));
        chk("t4_rdf",  w_rdf,  span(3, 3));
        chk("t4_wrf",  w_wrf,  span(8, 8));
        chk("t4_dack", w_dack, span(4, 4));
        chk("t4_hack", w_hack, span(9, 9));

        // Reset in the second strobe cycle of a write
        hc_req = 1; hc_wr = 1; hc_cmd = 0; hc_wdata = 16'hBEEF;
        @(posedge clk);
        repeat (3) @(negedge clk);
        chk("t5_wrf_before", wrf, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_async", {wrf, csf, doe, busy, addr, grant}, 7'b1100000);
        chk("t5_dout", dout, 16'h0000);
        hc_req = 0;
        repeat (2) @(negedge clk);
        chk("t5_no_ack", {hc_ack, dc_ack}, 2'b00);
        rst_n = 1'b1;
        run_trace(8);
        chk("t5_quiet_ack", v_hack | v_dack, 64'h0);
        chk("t5_quiet_csf", v_csf, 64'h0);
        hc_req = 1; hc_wr = 1; hc_wdata = 16'h0F0F;
        run_trace(16);
        chk("t5_hack", v_hack, span(6, 6));
        chk("t5_wrf",  v_wrf,  span(2, 5));
        chk("t5_dout2", r_dout[3], 16'h0F0F);

        // Random traffic against the reference model
        do_reset();
        next_idle = 0; last = 0; a_ack = -1; a_smp = -1; a_own = 0; a_wr = 0; a_cmd = 0; a_wd = 0;
        exp_rd[0] = 0; exp_rd[1] = 0;
        csf_run = 0; seen_low = 0; n_exp_ack = 0; n_seen_ack = 0;
        for (int e = 0; e < 10000; e++) begin
            @(posedge clk);
            if (e >= next_idle && (hc_req || dc_req)) begin
                a_own = dc_req && (!hc_req || !last);
                last  = a_own;
                a_wr  = a_own ? dc_wr : hc_wr;
                a_cmd = a_own ? dc_cmd : hc_cmd;
                a_wd  = a_own ? dc_wdata : hc_wdata;
                a_ack = e + 1 + S + B;
                a_smp = e + S + B;
                next_idle = e + S + B + R + 2;
            end
            if (e == a_smp && !a_wr) exp_rd[a_own] = din;
            @(negedge clk);
            exp_h = (a_ack == e + 1) && !a_own;
            exp_d = (a_ack == e + 1) && a_own;
            chk("rnd_hc_ack", hc_ack, exp_h);
            chk("rnd_dc_ack", dc_ack, exp_d);
            if (a_ack == e + 1) begin
                n_exp_ack++;
                chk("rnd_addr", addr, {a_own, a_cmd});
                chk("rnd_doe", doe, a_wr);
                if (a_wr) chk("rnd_dout", dout, a_wd);
                chk("rnd_hc_rdata", hc_rdata, exp_rd[0]);
                chk("rnd_dc_rdata", dc_rdata, exp_rd[1]);
            end
            n_seen_ack += int'(hc_ack) + int'(dc_ack);
            chk("rnd_strobe_overlap", rdf | wrf, 1'b1);
            chk("rnd_strobe_no_cs", csf & !(rdf & wrf), 1'b0);
            if (csf) begin
                csf_run++;
            end else begin
                if (seen_low && csf_run > 0) chk("rnd_csf_gap", csf_run >= R + 1, 1'b1);
                seen_low = 1;
                csf_run = 0;
            end
            din = 16'($urandom);
            if (hc_ack) hc_req = 1'b0;
            else if (!hc_req && $urandom_range(0, 3) == 0) begin
                hc_req = 1'b1; hc_wr = 1'($urandom); hc_cmd = 1'($urandom); hc_wdata = 16'($urandom);
            end
            if (dc_ack) dc_req = 1'b0;
            else if (!dc_req && $urandom_range(0, 3) == 0) begin
                dc_req = 1'b1; dc_wr = 1'($urandom); dc_cmd = 1'($urandom); dc_wdata = 16'($urandom);
            end
        end
        chk("rnd_ack_count", n_seen_ack, n_exp_ack);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
